conv_lsu_arbiter: RTL

- Shares the core's single data-memory port between two requesters: the core load/store path (port C) and the conv_unit load engine (port A, read-only).
- Core has priority; a starvation counter forces an accelerator grant after STARVE_LIMIT lost cycles.
- Responses return in order and are steered by a small tag FIFO.
- Sits between the LSU/conv_unit and the data-memory interface.

---
 rtl/conv_pkg.sv | 18 +
 rtl/arb_tag_fifo.sv | 62 ++++++
 rtl/conv_lsu_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv_unit datapath and its memory-port arbiter.
// The custom opcode constants live here so conv_unit can reuse them.
package conv_pkg;

   typedef enum logic {
      TAG_CORE = 1'b0,
      TAG_ACC  = 1'b1
   } port_tag_e;

   localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
   localparam logic [2:0] F3_SETBASE  = 3'd0;
   localparam logic [2:0] F3_SETSIZE  = 3'd1;
   localparam logic [2:0] F3_RUN      = 3'd2;

   localparam int DEF_STARVE_LIMIT    = 8;
   localparam int DEF_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order response steering FIFO: one port tag per accepted memory request.
// Push and pop in the same cycle are legal even when full.
module arb_tag_fifo
   import conv_pkg::*;
#(
   parameter int DEPTH = DEF_MAX_OUTSTANDING
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      push_i,
   input  port_tag_e push_tag_i,
   input  logic      pop_i,
   output port_tag_e head_tag_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   port_tag_e        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push_eff;
   logic             pop_eff;

   assign full_o     = (count_q == CNT_W'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign head_tag_o = mem_q[rd_ptr_q];

   // A full FIFO may still take a push when the head leaves in the same cycle.
   assign pop_eff  = pop_i & ~empty_o;
   assign push_eff = push_i & (~full_o | pop_eff);

   always_ff @(posedge clk_i) begin
      if (push_eff) begin
         mem_q[wr_ptr_q] <= push_tag_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_eff) begin
            wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (pop_eff) begin
            rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
         end
         case ({push_eff, pop_eff})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/conv_lsu_arbiter.sv
// Shares the single data-memory port between the core LSU (priority) and the
// read-only conv_unit load engine, with starvation relief and in-order steering.
module conv_lsu_arbiter
   import conv_pkg::*;
#(
   parameter int STARVE_LIMIT    = DEF_STARVE_LIMIT,
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        core_req_i,
   input  logic [31:0] core_addr_i,
   input  logic        core_wr_i,
   input  logic [31:0] core_wdata_i,
   output logic        core_ready_o,
   output logic        core_rvalid_o,
   output logic [31:0] core_rdata_o,
   input  logic        acc_req_i,
   input  logic [31:0] acc_addr_i,
   output logic        acc_ready_o,
   output logic        acc_rvalid_o,
   output logic [31:0] acc_rdata_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_wr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ready_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        err_o
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic          c_out_q;
   logic          a_out_q;
   logic          lock_q;
   port_tag_e     sel_q;
   logic [SW-1:0] starve_q;
   logic          err_q;

   logic          fifo_full;
   logic          fifo_empty;
   port_tag_e     head_tag;
   logic          c_elig;
   logic          a_elig;
   logic          req;
   port_tag_e     sel;
   logic          accept;
   logic          rsp_ok;

   arb_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (accept),
      .push_tag_i (sel),
      .pop_i      (rsp_ok),
      .head_tag_o (head_tag),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   // Eligibility looks only at registered state, so a held acc_req_i never duplicates.
   assign c_elig = core_req_i & ~c_out_q & ~fifo_full;
   assign a_elig = acc_req_i  & ~a_out_q & ~fifo_full;

   always_comb begin
      sel = TAG_CORE;
      req = 1'b0;
      if (lock_q) begin
         sel = sel_q;
         req = (sel_q == TAG_ACC) ? acc_req_i : core_req_i;
      end else if (a_elig && (!c_elig || starve_q >= SW'(STARVE_LIMIT))) begin
         sel = TAG_ACC;
         req = 1'b1;
      end else if (c_elig) begin
         sel = TAG_CORE;
         req = 1'b1;
      end
   end

   assign accept = req & mem_ready_i;
   assign rsp_ok = mem_rvalid_i & ~fifo_empty;

   assign mem_req_o   = req;
   assign mem_addr_o  = !req ? 32'd0 : (sel == TAG_ACC) ? acc_addr_i : core_addr_i;
   assign mem_wr_o    = req & (sel == TAG_CORE) & core_wr_i;
   assign mem_wdata_o = (req && sel == TAG_CORE) ? core_wdata_i : 32'd0;

   assign core_ready_o = accept & (sel == TAG_CORE);
   assign acc_ready_o  = accept & (sel == TAG_ACC);

   assign core_rvalid_o = rsp_ok & (head_tag == TAG_CORE);
   assign acc_rvalid_o  = rsp_ok & (head_tag == TAG_ACC);
   assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : 32'd0;
   assign acc_rdata_o   = acc_rvalid_o  ? mem_rdata_i : 32'd0;

   assign err_o = err_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         c_out_q  <= 1'b0;
         a_out_q  <= 1'b0;
         lock_q   <= 1'b0;
         sel_q    <= TAG_CORE;
         starve_q <= '0;
         err_q    <= 1'b0;
      end else begin
         lock_q <= req & ~mem_ready_i;
         sel_q  <= sel;

         // A port can't be answered and accepted in the same cycle, so order is moot.
         if (rsp_ok && head_tag == TAG_CORE) c_out_q <= 1'b0;
         if (accept && sel == TAG_CORE)      c_out_q <= 1'b1;
         if (rsp_ok && head_tag == TAG_ACC)  a_out_q <= 1'b0;
         if (accept && sel == TAG_ACC)       a_out_q <= 1'b1;

         if (mem_rvalid_i && fifo_empty) err_q <= 1'b1;

         if (!acc_req_i || (accept && sel == TAG_ACC)) begin
            starve_q <= '0;
         end else if (a_elig && starve_q < SW'(STARVE_LIMIT)) begin
            starve_q <= starve_q + SW'(1);
         end
      end
   end

endmodule
